// File: rtl/button_bank_if.sv
// Signal bundle for the push-button conditioner: raw inputs in, conditioned
// levels and event pulses out.
interface button_bank_if #(
    parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_press;
  logic [N_BTN-1:0] held;
  logic [N_BTN-1:0] rpt;

  modport master (
    output btn_in,
    input  level, press, release_pulse, long_press, held, rpt
  );

  modport slave (
    input  btn_in,
    output level, press, release_pulse, long_press, held, rpt
  );
endinterface

// File: rtl/button_bank.sv
// N-channel button conditioner: sync, debounce, press/release/long-press pulses; no backpressure.
// Level latency SYNC_STAGES+DB_CYCLES edges; auto-repeat enabled by BUTTON_AUTOREPEAT_EN.
module button_bank #(
    parameter int N_BTN         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 100000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  button_bank_if.slave bb
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HW  = $clog2(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] s;
  logic [DBW-1:0]   db_cnt [N_BTN];
  logic [N_BTN-1:0] level_q, press_q, release_q;
  logic [N_BTN-1:0] flip, rise, fall;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [HW-1:0]    hold_cnt [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [N_BTN-1:0] long_q, long_d, held_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bb.btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // rise/fall mark the edge on which level flips; press/release and the FSM key off them
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++) begin
      flip[i] = (s[i] != level_q[i]) && (db_cnt[i] == DB_LAST);
    end
    rise = flip & s;
    fall = flip & ~s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] == level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_q[i] <= s[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    long_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_cnt[i];
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i] = PRESSED;
            hold_d[i]  = '0;
          end
        end
        PRESSED: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else if (hold_cnt[i] == HOLD_LAST) begin
            state_d[i] = LONG;
            long_d[i]  = 1'b1;
          end else begin
            hold_d[i] = hold_cnt[i] + HW'(1);
          end
        end
        LONG: begin
          if (fall[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      long_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= state_d[i];
        hold_cnt[i] <= hold_d[i];
      end
    end
  end

  always_comb begin
    held_w = '0;
    for (int i = 0; i < N_BTN; i++) held_w[i] = (state_q[i] == LONG);
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0]    rep_cnt [N_BTN];
  logic [N_BTN-1:0] rpt_q;

  // Counter idles at zero outside LONG, so entry to LONG always starts a fresh period
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q <= '0;
      for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= 1'b0;
        if ((state_q[i] == LONG) && !fall[i]) begin
          if (rep_cnt[i] == REP_LAST) begin
            rep_cnt[i] <= '0;
            rpt_q[i]   <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + RW'(1);
          end
        end else begin
          rep_cnt[i] <= '0;
        end
      end
    end
  end

  assign bb.rpt = rpt_q;
`else
  assign bb.rpt = '0;
`endif

  assign bb.level         = level_q;
  assign bb.press         = press_q;
  assign bb.release_pulse = release_q;
  assign bb.long_press    = long_q;
  assign bb.held          = held_w;

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with small timing parameters (DB=4, LONG=10, REPEAT=3).
// Expected rpt activity follows BUTTON_AUTOREPEAT_EN.
module tb_button_bank;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] lp_acc, rpt_acc, press_acc, rel_acc;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [N-1:0] RPT_EXP = 2'b01;
`else
  localparam logic [N-1:0] RPT_EXP = 2'b00;
`endif

  button_bank_if #(.N_BTN(N)) bif ();

  button_bank #(
    .N_BTN(N), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bb    (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      lp_acc    |= bif.long_press;
      rpt_acc   |= bif.rpt;
      press_acc |= bif.press;
      rel_acc   |= bif.release_pulse;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr_acc();
    lp_acc = '0; rpt_acc = '0; press_acc = '0; rel_acc = '0;
  endtask

  initial begin
    reset = 1'b1;
    bif.btn_in = '0;
    clr_acc();
    tick(3);
    chk("rst_level", bif.level, 2'b00);
    chk("rst_press", bif.press, 2'b00);
    chk("rst_release", bif.release_pulse, 2'b00);
    chk("rst_long", bif.long_press, 2'b00);
    chk("rst_held", bif.held, 2'b00);
    chk("rst_rpt", bif.rpt, 2'b00);

    // 1: clean press on channel 0, first sampled at edge 1
    reset = 1'b0;
    bif.btn_in = 2'b01;
    tick(5);
    chk("t1_level_e5", bif.level, 2'b00);
    tick(1);
    chk("t1_level_e6", bif.level, 2'b01);
    chk("t1_press_e6", bif.press, 2'b01);
    chk("t1_release_e6", bif.release_pulse, 2'b00);
    tick(1);
    chk("t1_press_e7", bif.press, 2'b00);
    chk("t1_level_e7", bif.level, 2'b01);

    // 4: short press released before long-press threshold
    clr_acc();
    bif.btn_in = 2'b00;
    tick(5);
    chk("t4_level_hold", bif.level, 2'b01);
    tick(1);
    chk("t4_release", bif.release_pulse, 2'b01);
    chk("t4_level_low", bif.level, 2'b00);
    tick(1);
    chk("t4_release_end", bif.release_pulse, 2'b00);
    chk("t4_held", bif.held, 2'b00);
    chk("t4_no_long", lp_acc, 2'b00);

    // 2: three-cycle bounce never reaches level
    clr_acc();
    bif.btn_in = 2'b01;
    tick(3);
    bif.btn_in = 2'b00;
    tick(8);
    chk("t2_bounce_press", press_acc, 2'b00);
    chk("t2_bounce_level", bif.level, 2'b00);

    // 2b: high 3, low 1, then held: glitch restarts the count
    bif.btn_in = 2'b01;
    tick(3);
    bif.btn_in = 2'b00;
    tick(1);
    bif.btn_in = 2'b01;
    tick(5);
    chk("t2b_level_b9", bif.level, 2'b00);
    chk("t2b_press_acc", press_acc, 2'b00);
    tick(1);
    chk("t2b_level_b10", bif.level, 2'b01);
    chk("t2b_press_b10", bif.press, 2'b01);

    // 5: hold channel 0 through long press and auto-repeat
    clr_acc();
    tick(9);
    chk("t5_no_long_early", lp_acc, 2'b00);
    chk("t5_held_early", bif.held, 2'b00);
    tick(1);
    chk("t5_long", bif.long_press, 2'b01);
    chk("t5_held", bif.held, 2'b01);
    tick(2);
    chk("t5_rpt_before", rpt_acc, 2'b00);
    chk("t5_long_end", bif.long_press, 2'b00);
    tick(1);
    chk("t5_rpt_p3", bif.rpt, RPT_EXP);
    tick(1);
    chk("t5_rpt_gap", bif.rpt, 2'b00);
    tick(2);
    chk("t5_rpt_p6", bif.rpt, RPT_EXP);
    tick(3);
    chk("t5_rpt_p9", bif.rpt, RPT_EXP);
    bif.btn_in = 2'b00;
    tick(3);
    chk("t5_rpt_p12", bif.rpt, RPT_EXP);
    tick(2);
    rpt_acc = '0;
    tick(1);
    chk("t5_release", bif.release_pulse, 2'b01);
    chk("t5_held_drop", bif.held, 2'b00);
    chk("t5_rpt_rel", bif.rpt, 2'b00);
    tick(5);
    chk("t5_rpt_after", rpt_acc, 2'b00);

    // 3: long press on channel 1
    clr_acc();
    bif.btn_in = 2'b10;
    tick(6);
    chk("t3_press", bif.press, 2'b10);
    lp_acc = '0;
    tick(9);
    chk("t3_no_long_early", lp_acc, 2'b00);
    tick(1);
    chk("t3_long", bif.long_press, 2'b10);
    chk("t3_held", bif.held, 2'b10);
    tick(1);
    chk("t3_long_end", bif.long_press, 2'b00);
    bif.btn_in = 2'b00;
    tick(5);
    chk("t3_held_pre", bif.held, 2'b10);
    chk("t3_release_pre", bif.release_pulse, 2'b00);
    tick(1);
    chk("t3_release", bif.release_pulse, 2'b10);
    chk("t3_held_drop", bif.held, 2'b00);
    tick(2);

    // 6: simultaneous press, then reset while held
    clr_acc();
    bif.btn_in = 2'b11;
    tick(6);
    chk("t6_press_both", bif.press, 2'b11);
    tick(2);
    chk("t6_level_both", bif.level, 2'b11);
    rel_acc = '0;
    reset = 1'b1;
    tick(1);
    chk("t6_rst_level", bif.level, 2'b00);
    chk("t6_rst_release", bif.release_pulse, 2'b00);
    chk("t6_rst_held", bif.held, 2'b00);
    chk("t6_rst_press", bif.press, 2'b00);
    bif.btn_in = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("t6_no_release", rel_acc, 2'b00);
    chk("t6_level_after", bif.level, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
